// File: rtl/apb_regfile_slave.sv
// APB3 completion slave backed by a parametrised register file with optional
// wait states, byte strobes, read-only status mapping and PSLVERR reporting.
module apb_regfile_slave #(
  parameter int                  DATA_W      = 32,
  parameter int                  ADDR_W      = 10,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic [ADDR_W-1:0]          paddr_i,
  input  logic                       pwrite_i,
  input  logic [DATA_W-1:0]          pwdata_i,
  input  logic [DATA_W/8-1:0]        pstrb_i,
  output logic [DATA_W-1:0]          prdata_o,
  output logic                       pready_o,
  output logic                       pslverr_o,
  input  logic [NUM_REGS*DATA_W-1:0] status_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFS;
  localparam int CNT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic [IDX_W-1:0]  w_idx;
  logic              w_misalign;
  logic              w_in_range;
  logic              w_ro;
  logic              w_err;
  logic              w_access;
  logic              w_cnt_hit;
  logic              w_pready;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_words [NUM_REGS];

  // Status words behind RW registers are intentionally ignored.
  logic              w_unused_status;
  assign w_unused_status = ^status_i;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign w_idx = paddr_i[ADDR_W-1:OFS];

  generate
    if (OFS == 0) begin : g_no_ofs
      assign w_misalign = 1'b0;
    end else begin : g_ofs
      assign w_misalign = |paddr_i[OFS-1:0];
    end
  endgenerate

  // Exact-match decode: an index beyond NUM_REGS hits nothing, so it is never
  // aliased onto a real register.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    w_in_range = 1'b0;
    w_ro       = 1'b0;
    w_rdata    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_in_range = 1'b1;
        w_ro       = RO_MASK[i];
        w_rdata    = w_words[i];
      end
    end
  end

  assign w_err     = w_misalign | ~w_in_range | (pwrite_i & w_ro);
  assign w_access  = psel_i & penable_i;
  assign w_cnt_hit = (r_cnt == CNT_W'(WAIT_CYCLES));

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_access && (WAIT_CYCLES != 0)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        // A dropped psel is a master abort: return without a response.
        if (!psel_i || w_cnt_hit) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_pready = 1'b0;
    case (r_state)
      S_IDLE:  w_pready = w_access && (WAIT_CYCLES == 0);
      S_WAIT:  w_pready = w_access && w_cnt_hit;
      default: w_pready = 1'b0;
    endcase
    if (reset) begin
      w_pready = 1'b0;
    end
  end

  assign pready_o  = w_pready;
  assign pslverr_o = w_pready & w_err;
  assign prdata_o  = (w_pready && !w_misalign) ? w_rdata : '0;
  assign w_wr_en   = w_pready & pwrite_i & ~w_err;

  // ---------------------------------------------------------------------------
  // Register storage: RO slots are pure status taps, RW slots hold flops
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
        assign w_words[i] = status_i[i*DATA_W +: DATA_W];
      end else begin : g_rw
        logic [DATA_W-1:0] r_word;

        // NOTE: the register file is flop-based and must read 0 after reset,
        // so every word is explicitly cleared rather than left to a RAM.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_word <= '0;
          end else if (w_wr_en && (w_idx == IDX_W'(i))) begin
            for (int b = 0; b < NB; b++) begin
              if (pstrb_i[b]) begin
                r_word[8*b +: 8] <= pwdata_i[8*b +: 8];
              end
            end
          end
        end

        assign w_words[i] = r_word;
      end

      assign regs_o[i*DATA_W +: DATA_W] = w_words[i];
    end
  endgenerate

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three instances cover zero-wait with an
// RO status register, three wait states, and two wait states with mid-transfer reset.
module tb_apb_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pready;
  logic [2:0]        pslverr;
  logic [DW-1:0]     prdata [3];
  logic [NR*DW-1:0]  regs_v [3];
  logic [NR*DW-1:0]  status0;
  logic [NR*DW-1:0]  status_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign status0  = {{(NR*DW-32){1'b0}}, 32'h0000_CAFE};
  assign status_z = '0;

  apb_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(0), .RO_MASK(16'h0001)
  ) u_dut0 (
    .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
    .status_i(status0), .regs_o(regs_v[0])
  );

  apb_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(3), .RO_MASK(16'h0000)
  ) u_dut1 (
    .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
    .status_i(status_z), .regs_o(regs_v[1])
  );

  apb_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(2), .RO_MASK(16'h0000)
  ) u_dut2 (
    .clk(clk), .reset(reset), .psel_i(psel[2]), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]),
    .status_i(status_z), .regs_o(regs_v[2])
  );

  task automatic check(input string tag, input logic [NR*DW-1:0] act,
                       input logic [NR*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int d, input int i);
    return regs_v[d][i*DW +: DW];
  endfunction

  // One full APB transfer on instance d; lat is the number of access cycles
  // before pready (-1 if it never came within the budget).
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [3:0] st,
                      output logic [DW-1:0] rd, output logic er, output int lat);
    @(posedge clk); #1;
    psel     = '0;
    psel[d]  = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wd;
    pstrb    = st;
    @(posedge clk); #1;
    penable  = 1'b1;
    lat      = -1;
    rd       = '0;
    er       = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pready[d]) begin
        rd  = prdata[d];
        er  = pslverr[d];
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat;
  int            n_rdy;

  initial begin
    reset   = 1'b1;
    psel    = 3'b001;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 10'h008;
    pwdata  = 32'hFFFF_FFFF;
    pstrb   = 4'hF;

    // Reset held 2 cycles with an access pending: no response may appear.
    repeat (2) begin
      @(negedge clk);
      check("rst_pready", pready[0], 1'b0);
      check("rst_pslverr", pslverr[0], 1'b0);
      check("rst_prdata", prdata[0], '0);
    end
    @(posedge clk); #1;
    reset   = 1'b0;
    psel    = '0;
    penable = 1'b0;
    @(negedge clk);
    check("rst_regs0", regs_v[0], status0);
    check("rst_regs1", regs_v[1], '0);
    check("post_rst_pready", pready[0], 1'b0);

    // Zero-wait write / read
    xfer(0, 1'b1, 10'h008, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("w0_lat", lat, 0);
    check("w0_err", er, 1'b0);
    check("w0_regs_w2", word(0, 2), 32'hDEAD_BEEF);
    xfer(0, 1'b0, 10'h008, 32'h0, 4'h0, rd, er, lat);
    check("r0_lat", lat, 0);
    check("r0_err", er, 1'b0);
    check("r0_data", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("idle_prdata", prdata[0], '0);

    // Byte strobes
    xfer(0, 1'b1, 10'h00C, 32'h1122_3344, 4'hF, rd, er, lat);
    xfer(0, 1'b1, 10'h00C, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    check("strb_regs_w3", word(0, 3), 32'h11BB_33DD);
    xfer(0, 1'b0, 10'h00C, 32'h0, 4'h0, rd, er, lat);
    check("strb_read", rd, 32'h11BB_33DD);

    // Highest valid index
    xfer(0, 1'b1, 10'h03C, 32'h0F0F_0F0F, 4'hF, rd, er, lat);
    check("top_err", er, 1'b0);
    check("top_regs_w15", word(0, 15), 32'h0F0F_0F0F);

    // Error responses
    xfer(0, 1'b1, 10'h006, 32'h1234_5678, 4'hF, rd, er, lat);
    check("mis_w_lat", lat, 0);
    check("mis_w_err", er, 1'b1);
    check("mis_w_regs_w1", word(0, 1), 32'h0);
    xfer(0, 1'b0, 10'h006, 32'h0, 4'h0, rd, er, lat);
    check("mis_r_err", er, 1'b1);
    check("mis_r_data", rd, 32'h0);
    xfer(0, 1'b0, 10'h040, 32'h0, 4'h0, rd, er, lat);
    check("oor_r_lat", lat, 0);
    check("oor_r_err", er, 1'b1);
    check("oor_r_data", rd, 32'h0);
    xfer(0, 1'b1, 10'h040, 32'h5555_5555, 4'hF, rd, er, lat);
    check("oor_w_err", er, 1'b1);
    check("oor_w_regs0", regs_v[0][NR*DW-1:32], regs_v[0][NR*DW-1:32] & ~{(NR*DW-32){1'b0}});
    xfer(0, 1'b1, 10'h000, 32'h0000_1234, 4'hF, rd, er, lat);
    check("ro_w_err", er, 1'b1);
    check("ro_w_regs_w0", word(0, 0), 32'h0000_CAFE);
    xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, rd, er, lat);
    check("ro_r_err", er, 1'b0);
    check("ro_r_data", rd, 32'h0000_CAFE);

    // Three wait states
    xfer(1, 1'b1, 10'h004, 32'h0000_0005, 4'hF, rd, er, lat);
    check("w3_lat", lat, 3);
    check("w3_err", er, 1'b0);
    check("w3_regs_w1", word(1, 1), 32'h5);
    xfer(1, 1'b0, 10'h002, 32'h0, 4'h0, rd, er, lat);
    check("w3_mis_lat", lat, 3);
    check("w3_mis_err", er, 1'b1);

    // Master abort at A0+1
    @(posedge clk); #1;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 10'h004; pwdata = 32'h9; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    n_rdy = 0;
    @(negedge clk);
    if (pready[1]) n_rdy++;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready[1]) n_rdy++;
    end
    check("abort_no_ready", n_rdy, 0);
    check("abort_regs_w1", word(1, 1), 32'h5);
    xfer(1, 1'b0, 10'h004, 32'h0, 4'h0, rd, er, lat);
    check("after_abort_lat", lat, 3);
    check("after_abort_data", rd, 32'h5);

    // Reset asserted at A0+1 of a two-wait write
    @(posedge clk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 10'h010; pwdata = 32'h7; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    n_rdy = 0;
    @(negedge clk);
    if (pready[2]) n_rdy++;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (pready[2]) n_rdy++;
      @(posedge clk); #1;
    end
    reset = 1'b0; psel = '0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready[2]) n_rdy++;
    end
    check("rst_mid_no_ready", n_rdy, 0);
    check("rst_mid_regs_w4", word(2, 4), 32'h0);
    check("rst_mid_dut0_w2", word(0, 2), 32'h0);
    check("rst_mid_dut1_w1", word(1, 1), 32'h0);
    xfer(2, 1'b1, 10'h010, 32'h7, 4'hF, rd, er, lat);
    check("post_rst_w_lat", lat, 2);
    check("post_rst_regs_w4", word(2, 4), 32'h7);
    xfer(2, 1'b0, 10'h010, 32'h0, 4'h0, rd, er, lat);
    check("post_rst_r_data", rd, 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
